imem_loader: RTL



---
 rtl/imem_loader_pkg.sv | 33 +++
 rtl/imem_loader.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader.
// Package imem_pkg: memory geometry shared with the instruction memory,
// the loader state encoding and the program-length check.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN (adds the CHECK state).
package imem_pkg;

  // Instruction memory geometry, shared with the read-side ROM path.
  localparam int IMEM_DEPTH = 16;
  localparam int IMEM_AW    = 4;

  // Largest program length the count byte may announce.
  localparam logic [7:0] MAX_COUNT = 8'(IMEM_DEPTH);

  // Loader states; CHECK exists only when the trailing checksum is enabled.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_COUNT = 3'd1,
    ST_HI    = 3'd2,
    ST_LO    = 3'd3,
    ST_WRITE = 3'd4,
    ST_DONE  = 3'd5,
    ST_ERR   = 3'd6
`ifdef IMEM_LOADER_CHECKSUM_EN
    , ST_CHECK = 3'd7
`endif
  } loader_state_t;

  // A program length is usable when it is non-zero and fits in memory.
  function automatic logic count_is_valid(input logic [7:0] n, input logic [7:0] max_n);
    return (n != 8'd0) && (n <= max_n);
  endfunction

endpackage

// File: rtl/imem_loader.sv
// Boot-time instruction memory writer.
// Receives a byte stream (count byte, then high/low byte pairs) over a
// valid/ready handshake and writes one 16-bit word per pair into the
// instruction memory, holding the CPU until the whole program is in place.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN -- when defined, a trailing
// byte must equal the XOR of all data bytes before the load counts as done.
module imem_loader
  import imem_pkg::*;
#(
  parameter int DEPTH = IMEM_DEPTH,
  parameter int AW    = IMEM_AW
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic [7:0]    rx_data,
  input  logic          rx_valid,
  output logic          rx_ready,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [15:0]   wr_data,
  output logic          cpu_hold,
  output logic          done,
  output logic          error,
  output logic [AW:0]   words_loaded
);

  localparam logic [7:0] DEPTH_B = 8'(DEPTH);
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_W = (AW+1)'(1);

  loader_state_t state_r;
  loader_state_t state_nxt_s;

  logic [AW:0]   count_r;
  logic [AW:0]   count_nxt_s;
  logic [AW:0]   words_r;
  logic [AW:0]   words_nxt_s;
  logic [AW:0]   words_inc_s;
  logic [AW-1:0] addr_r;
  logic [AW-1:0] addr_nxt_s;
  logic [15:0]   data_r;
  logic [15:0]   data_nxt_s;

  logic rx_ready_r;
  logic wr_en_r;
  logic cpu_hold_r;
  logic done_r;
  logic error_r;
  logic accept_s;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] csum_r;
  logic [7:0] csum_nxt_s;
`endif

  // A byte moves only when the loader has advertised ready.
  assign accept_s = rx_valid & rx_ready_r;

  // Saturating word counter value used when leaving WRITE.
  assign words_inc_s = (words_r < DEPTH_W) ? (words_r + ONE_W) : words_r;

  // Next-state and datapath update for the loader FSM.
  always_comb begin
    state_nxt_s = state_r;
    count_nxt_s = count_r;
    words_nxt_s = words_r;
    addr_nxt_s  = addr_r;
    data_nxt_s  = data_r;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_nxt_s  = csum_r;
`endif
    case (state_r)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          state_nxt_s = ST_COUNT;
          words_nxt_s = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_nxt_s  = 8'h00;
`endif
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_COUNT: begin
        if (accept_s) begin
          if (count_is_valid(rx_data, DEPTH_B)) begin
            count_nxt_s = rx_data[AW:0];
            state_nxt_s = ST_HI;
          end else begin
            state_nxt_s = ST_ERR;
          end
        end else begin
          state_nxt_s = ST_COUNT;
        end
      end
      ST_HI: begin
        if (accept_s) begin
          data_nxt_s[15:8] = rx_data;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_nxt_s = csum_r ^ rx_data;
`endif
          state_nxt_s = ST_LO;
        end else begin
          state_nxt_s = ST_HI;
        end
      end
      ST_LO: begin
        if (accept_s) begin
          data_nxt_s[7:0] = rx_data;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_nxt_s = csum_r ^ rx_data;
`endif
          // The write address is the number of words already committed.
          addr_nxt_s  = words_r[AW-1:0];
          state_nxt_s = ST_WRITE;
        end else begin
          state_nxt_s = ST_LO;
        end
      end
      ST_WRITE: begin
        words_nxt_s = words_inc_s;
        if (words_inc_s == count_r) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_nxt_s = ST_CHECK;
`else
          state_nxt_s = ST_DONE;
`endif
        end else begin
          state_nxt_s = ST_HI;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      ST_CHECK: begin
        if (accept_s) begin
          if (rx_data == csum_r) begin
            state_nxt_s = ST_DONE;
          end else begin
            state_nxt_s = ST_ERR;
          end
        end else begin
          state_nxt_s = ST_CHECK;
        end
      end
`endif
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs; outputs decode the next state
  // so they are valid in the same cycle the FSM sits in that state.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r    <= ST_IDLE;
      count_r    <= '0;
      words_r    <= '0;
      addr_r     <= '0;
      data_r     <= 16'h0000;
      rx_ready_r <= 1'b0;
      wr_en_r    <= 1'b0;
      cpu_hold_r <= 1'b1;
      done_r     <= 1'b0;
      error_r    <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_r     <= 8'h00;
`endif
    end else begin
      state_r    <= state_nxt_s;
      count_r    <= count_nxt_s;
      words_r    <= words_nxt_s;
      addr_r     <= addr_nxt_s;
      data_r     <= data_nxt_s;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_r     <= csum_nxt_s;
      rx_ready_r <= (state_nxt_s == ST_COUNT) || (state_nxt_s == ST_HI) ||
                    (state_nxt_s == ST_LO) || (state_nxt_s == ST_CHECK);
`else
      rx_ready_r <= (state_nxt_s == ST_COUNT) || (state_nxt_s == ST_HI) ||
                    (state_nxt_s == ST_LO);
`endif
      wr_en_r    <= (state_nxt_s == ST_WRITE);
      cpu_hold_r <= (state_nxt_s != ST_DONE);
      done_r     <= (state_nxt_s == ST_DONE);
      error_r    <= (state_nxt_s == ST_ERR);
    end
  end

  assign rx_ready     = rx_ready_r;
  assign wr_en        = wr_en_r;
  assign wr_addr      = addr_r;
  assign wr_data      = data_r;
  assign cpu_hold     = cpu_hold_r;
  assign done         = done_r;
  assign error        = error_r;
  assign words_loaded = words_r;

endmodule
